mvau_axis: RTL and testbench
============================

MVAU_AXIS -- requirements
Module: mvau_axis

Interface
REQ-001 SHALL have parameter MatrixW, default 4: input vector length.
REQ-002 SHALL have parameter MatrixH, default 4: output vector length.
REQ-003 SHALL have parameter SIMD, default 2: input lanes per beat. MatrixW % SIMD == 0.
REQ-004 SHALL have parameter PE, default 2: output lanes. MatrixH % PE == 0.
REQ-005 SHALL have parameters TSrcI=8, TW=8, TDstI=16: activation, weight and accumulator/output widths.
REQ-006 SHALL derive SF=MatrixW/SIMD, NF=MatrixH/PE, WMEM_DEPTH=SF*NF and WMEM_ADDR_BW=max(1,$clog2(WMEM_DEPTH)).
REQ-007 SHALL have port clk, input, 1 bit: the only clock.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port in, input, SIMD*TSrcI bits: activation beat. Lane s is at [s*TSrcI +: TSrcI].
REQ-010 SHALL have ports in_v (input, 1 bit) and in_rdy (output, 1 bit): input handshake.
REQ-011 SHALL have ports out (output, PE*TDstI bits) and out_v (output, 1 bit). Lane p is at [p*TDstI +: TDstI].
REQ-012 SHALL have port out_rdy, input, 1 bit: downstream ready.
REQ-013 SHALL have ports wgt_we (input, 1 bit), wgt_addr (input, WMEM_ADDR_BW bits) and wgt_data (input, PE*SIMD*TW bits): weight write port. Element (p,s) is at [(p*SIMD+s)*TW +: TW].
REQ-014 SHALL have port busy, output, 1 bit: high when not idle.

Function
REQ-015 SHALL hold an internal weight RAM of WMEM_DEPTH words. Address nf*SF+sf holds the tile for output chunk nf and input chunk sf.
REQ-016 SHALL define idle as: state FILL, sf==0, nf==0 and out_v==0.
REQ-017 SHALL write wgt_data to wgt_addr at the clock edge when wgt_we is high and the block is idle.
- Write is ignored when not idle.
- Write is ignored when wgt_addr >= WMEM_DEPTH.
REQ-018 SHALL hold an activation buffer of SF entries, each SIMD*TSrcI bits.
REQ-019 SHALL implement FSM states FILL and REUSE.
REQ-020 SHALL define stall = (sf==SF-1) && out_v && !out_rdy.
REQ-021 In FILL, in_rdy SHALL equal !stall. In REUSE, in_rdy SHALL be 0.
REQ-022 SHALL define step as: (FILL && in_v && in_rdy) or (REUSE && !stall).
REQ-023 In FILL, the operand SHALL be in. In REUSE, the operand SHALL be buffer[sf].
REQ-024 On a FILL step, in SHALL be written to buffer[sf].
REQ-025 On each step, SHALL compute for each lane p: dot_p = sum over s of signed(act_s) * signed(w[p][s]).
- Products are sign-extended to TDstI.
- The sum wraps modulo 2^TDstI.
REQ-026 On each step, the accumulator SHALL update as acc_p <= (sf==0 ? 0 : acc_p) + dot_p, modulo 2^TDstI.
REQ-027 On a step with sf==SF-1:
- out SHALL be loaded with the completed sums (acc_p + dot_p).
- out_v SHALL be set to 1 in the next cycle.
- Latency is 1 cycle after the final beat or step.
REQ-028 out_v SHALL clear on the out_rdy handshake unless a new result loads in the same cycle; in that case out_v stays 1 with the new data.
REQ-029 out and out_v SHALL be stable while out_v && !out_rdy.
REQ-030 Counters SHALL advance on each step: sf increments and wraps at SF-1.
- On sf wrap, nf increments and wraps at NF-1.
REQ-031 FSM transitions SHALL be:
- FILL to REUSE on the step with sf==SF-1, nf==0, when NF>1.
- REUSE to FILL on the step with sf==SF-1, nf==NF-1.
- With NF==1, FILL SHALL be permanent.
REQ-032 SHALL sustain one step per cycle when out_rdy is held high, with no bubbles between vectors.
REQ-033 busy SHALL equal !idle.

Reset
REQ-034 With rst_n low at a clock edge:
- state=FILL, sf=0, nf=0, acc=0.
- out_v=0, out=0.
REQ-035 in_rdy SHALL be 1 and busy SHALL be 0 in the cycle after reset.
REQ-036 Reset SHALL NOT clear the weight RAM or the activation buffer.
REQ-037 Reset mid-vector SHALL discard the partial result.

Verification
REQ-038 Basic run, default parameters:
- Stimulus: weights addr0,1 all +1; addr2,3 all -1. Inputs {1,2} then {3,4}, out_rdy=1.
- Response: out={10,10} one cycle after the 2nd beat, then {0xFFF6,0xFFF6} the next cycle.
- in_rdy=0 during REUSE.
REQ-039 Backpressure:
- Stimulus: as REQ-038 but out_rdy=0.
- Response: first result holds on out with out_v=1, REUSE stalls at sf=1, and the second result is not lost.
- After out_rdy=1, the results appear in order.
REQ-040 Wraparound:
- Stimulus: TDstI=8, all weights 16, inputs all 16.
- Response: every output lane = 0x00 (1024 mod 256).
REQ-041 Weight write guard: wgt_we asserted while busy=1 leaves the RAM unchanged, and a repeat run gives identical outputs.
REQ-042 Mid-operation reset:
- Stimulus: rst_n low after the first beat.
- Response: out_v=0, in_rdy=1, busy=0.
- A rerun without reloading weights reproduces the REQ-038 outputs.
REQ-043 Back-to-back vectors with out_rdy=1: four vectors streamed continuously give 8 results on 8 consecutive-step cycles with no gaps besides REUSE cycles.

Source files
------------

// File: rtl/mvau_axis.sv
// Matrix-vector activation unit with an AXI-stream-like handshake: streams SIMD-wide
// activation beats against a locally stored weight RAM, emitting PE output lanes per step.
module mvau_axis #(
    parameter int MatrixW = 4,
    parameter int MatrixH = 4,
    parameter int SIMD    = 2,
    parameter int PE      = 2,
    parameter int TSrcI   = 8,
    parameter int TW      = 8,
    parameter int TDstI   = 16,
    localparam int SF           = MatrixW / SIMD,
    localparam int NF           = MatrixH / PE,
    localparam int WMEM_DEPTH   = SF * NF,
    localparam int WMEM_ADDR_BW = ($clog2(WMEM_DEPTH) > 1) ? $clog2(WMEM_DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SIMD*TSrcI-1:0]        in,
    input  logic                         in_v,
    output logic                         in_rdy,
    output logic [PE*TDstI-1:0]          out,
    output logic                         out_v,
    input  logic                         out_rdy,
    input  logic                         wgt_we,
    input  logic [WMEM_ADDR_BW-1:0]      wgt_addr,
    input  logic [PE*SIMD*TW-1:0]        wgt_data,
    output logic                         busy
);
    localparam int SF_BW = ($clog2(SF) > 1) ? $clog2(SF) : 1;
    localparam int NF_BW = ($clog2(NF) > 1) ? $clog2(NF) : 1;
    localparam logic [SF_BW-1:0]        SF_LAST = SF_BW'(SF - 1);
    localparam logic [NF_BW-1:0]        NF_LAST = NF_BW'(NF - 1);
    localparam logic [WMEM_ADDR_BW-1:0] SF_A    = WMEM_ADDR_BW'(SF);
    localparam logic [WMEM_ADDR_BW:0]   DEPTH_X = (WMEM_ADDR_BW + 1)'(WMEM_DEPTH);

    typedef enum logic {FILL, REUSE} state_t;

    state_t                    state_q, state_d;
    logic [SF_BW-1:0]          sf_q;
    logic [NF_BW-1:0]          nf_q;
    logic [PE*SIMD*TW-1:0]     wmem [WMEM_DEPTH];
    logic [SIMD*TSrcI-1:0]     abuf [SF];
    logic signed [TDstI-1:0]   acc_p0 [PE];
    logic [PE*TDstI-1:0]       out_p1;
    logic                      vld_p1;

    logic                      last, nf_last, idle, stall, step;
    logic [SIMD*TSrcI-1:0]     act;
    logic [WMEM_ADDR_BW-1:0]   rd_addr;
    logic [PE*SIMD*TW-1:0]     wrow;
    logic signed [TDstI-1:0]   sum_c [PE];

    // Dot product of one PE lane; products and the running sum wrap at TDstI bits.
    function automatic logic signed [TDstI-1:0] lane_dot(
        input logic [SIMD*TSrcI-1:0] a,
        input logic [PE*SIMD*TW-1:0] w,
        input int                    p
    );
        logic signed [TDstI-1:0]      s_acc;
        logic signed [TSrcI-1:0]      x;
        logic signed [TW-1:0]         k;
        logic signed [TSrcI+TW-1:0]   prod;
        s_acc = '0;
        for (int s = 0; s < SIMD; s++) begin
            x     = a[s*TSrcI +: TSrcI];
            k     = w[(p*SIMD+s)*TW +: TW];
            prod  = (TSrcI+TW)'(x) * (TSrcI+TW)'(k);
            s_acc = s_acc + TDstI'(prod);
        end
        return s_acc;
    endfunction

    assign last    = (sf_q == SF_LAST);
    assign nf_last = (nf_q == NF_LAST);
    assign idle    = (state_q == FILL) && (sf_q == '0) && (nf_q == '0) && !vld_p1;
    assign busy    = !idle;
    assign stall   = last && vld_p1 && !out_rdy;
    assign in_rdy  = (state_q == FILL) && !stall;
    assign step    = (state_q == FILL) ? (in_v && in_rdy) : !stall;
    assign act     = (state_q == FILL) ? in : abuf[sf_q];
    assign rd_addr = WMEM_ADDR_BW'(nf_q) * SF_A + WMEM_ADDR_BW'(sf_q);
    assign wrow    = wmem[rd_addr];
    assign out     = out_p1;
    assign out_v   = vld_p1;

    always_comb begin
        for (int p = 0; p < PE; p++) begin
            sum_c[p] = ((sf_q == '0) ? TDstI'(0) : acc_p0[p]) + lane_dot(act, wrow, p);
        end
    end

    always_comb begin
        state_d = state_q;
        if (step && last) begin
            if (state_q == FILL && nf_q == '0 && NF > 1) begin
                state_d = REUSE;
            end else if (state_q == REUSE && nf_last) begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            sf_q    <= '0;
            nf_q    <= '0;
            vld_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (step) begin
                sf_q <= last ? '0 : sf_q + SF_BW'(1);
                if (last) begin
                    nf_q <= nf_last ? '0 : nf_q + NF_BW'(1);
                end
            end
            // A freshly completed vector takes priority over clearing on handshake.
            if (step && last) begin
                vld_p1 <= 1'b1;
            end else if (out_rdy) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // p0: per-lane accumulation; p1: completed sums held for the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < PE; p++) acc_p0[p] <= '0;
            out_p1 <= '0;
        end else if (step) begin
            for (int p = 0; p < PE; p++) acc_p0[p] <= sum_c[p];
            if (last) begin
                for (int p = 0; p < PE; p++) out_p1[p*TDstI +: TDstI] <= sum_c[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wgt_we && idle && ({1'b0, wgt_addr} < DEPTH_X)) begin
            wmem[wgt_addr] <= wgt_data;
        end
        if (step && state_q == FILL) begin
            abuf[sf_q] <= in;
        end
    end
endmodule

// File: tb/tb_mvau_axis.sv
// Bench for mvau_axis: directed handshake timing plus randomized vectors against a
// matrix-times-vector reference; a second instance with an 8-bit accumulator shares inputs.
module tb_mvau_axis;
    localparam int MW = 4, MH = 4, SIMD = 2, PE = 2, TI = 8, TW = 8, TD = 16;
    localparam int SF = MW / SIMD, NF = MH / PE, ABW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [SIMD*TI-1:0]    in;
    logic                  in_v, in_rdy, out_rdy, out_v, busy;
    logic [PE*TD-1:0]      out;
    logic                  wgt_we;
    logic [ABW-1:0]        wgt_addr;
    logic [PE*SIMD*TW-1:0] wgt_data;
    logic [PE*8-1:0]       out8;
    logic                  out_v8, in_rdy8, busy8;

    mvau_axis dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_v(in_v), .in_rdy(in_rdy),
        .out(out), .out_v(out_v), .out_rdy(out_rdy), .wgt_we(wgt_we),
        .wgt_addr(wgt_addr), .wgt_data(wgt_data), .busy(busy)
    );

    mvau_axis #(.TDstI(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(in), .in_v(in_v), .in_rdy(in_rdy8),
        .out(out8), .out_v(out_v8), .out_rdy(out_rdy), .wgt_we(wgt_we),
        .wgt_addr(wgt_addr), .wgt_data(wgt_data), .busy(busy8)
    );

    int tests = 0;
    int fails = 0;
    byte W [MH][MW];
    byte X [4][MW];
    logic [PE*TD-1:0] q_obs[$], q_exp[$];
    logic [PE*8-1:0]  q8_obs[$], q8_exp[$];
    bit acc_s;
    int cyc;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        acc_s = in_v && in_rdy;
        if (out_v && out_rdy) q_obs.push_back(out);
        if (out_v8 && out_rdy) q8_obs.push_back(out8);
        @(posedge clk);
        #1;
    endtask

    task automatic load_w();
        for (int nf = 0; nf < NF; nf++) begin
            for (int sf = 0; sf < SF; sf++) begin
                wgt_addr = ABW'(nf*SF + sf);
                for (int p = 0; p < PE; p++)
                    for (int s = 0; s < SIMD; s++)
                        wgt_data[(p*SIMD+s)*TW +: TW] = W[nf*PE+p][sf*SIMD+s];
                wgt_we = 1'b1;
                cycle();
            end
        end
        wgt_we = 1'b0;
    endtask

    // y = W * x, each row wrapped to the accumulator width, grouped PE rows per result.
    task automatic model(input int v);
        logic [PE*TD-1:0] wd;
        logic [PE*8-1:0]  w8;
        int sum;
        for (int nf = 0; nf < NF; nf++) begin
            for (int p = 0; p < PE; p++) begin
                sum = 0;
                for (int k = 0; k < MW; k++) sum += int'(X[v][k]) * int'(W[nf*PE+p][k]);
                wd[p*TD +: TD] = sum[15:0];
                w8[p*8 +: 8]   = sum[7:0];
            end
            q_exp.push_back(wd);
            q8_exp.push_back(w8);
        end
    endtask

    task automatic run(input string tag, input int n, input int mode, output int cycles);
        int idx, v, sf;
        q_obs.delete(); q_exp.delete(); q8_obs.delete(); q8_exp.delete();
        for (int i = 0; i < n; i++) model(i);
        idx = 0;
        cycles = 0;
        while ((q_obs.size() < n*NF || idx < n*SF) && cycles < 500) begin
            if (idx < n*SF) begin
                v  = idx / SF;
                sf = idx % SF;
                for (int s = 0; s < SIMD; s++) in[s*TI +: TI] = X[v][sf*SIMD+s];
                in_v = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else begin
                in_v = 1'b0;
            end
            out_rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle();
            cycles++;
            if (acc_s) idx++;
        end
        in_v = 1'b0;
        out_rdy = 1'b1;
        chk({tag, "_count"}, 64'(q_obs.size()), 64'(n*NF));
        chk({tag, "_count8"}, 64'(q8_obs.size()), 64'(n*NF));
        for (int i = 0; i < n*NF; i++) begin
            chk({tag, "_res"}, (i < q_obs.size()) ? q_obs[i] : 'x, q_exp[i]);
            chk({tag, "_res8"}, (i < q8_obs.size()) ? q8_obs[i] : 'x, q8_exp[i]);
        end
    endtask

    task automatic set_directed();
        for (int h = 0; h < MH; h++)
            for (int k = 0; k < MW; k++) W[h][k] = (h < PE) ? 8'sd1 : -8'sd1;
        for (int k = 0; k < MW; k++) X[0][k] = byte'(k + 1);
    endtask

    initial begin
        in = '0; in_v = 1'b0; out_rdy = 1'b1;
        wgt_we = 1'b0; wgt_addr = '0; wgt_data = '0;
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_out_v", 64'(out_v), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);

        set_directed();
        load_w();

        // Basic run with cycle-exact timing.
        in = {8'd2, 8'd1}; in_v = 1'b1;
        cycle();
        in = {8'd4, 8'd3};
        cycle();
        in_v = 1'b0;
        chk("basic_v1", 64'(out_v), 64'd1);
        chk("basic_o1", 64'(out), 64'h000A_000A);
        chk("basic_rdy_reuse", 64'(in_rdy), 64'd0);
        chk("basic_busy", 64'(busy), 64'd1);
        cycle();
        chk("basic_rdy_reuse2", 64'(in_rdy), 64'd0);
        chk("basic_v_clr", 64'(out_v), 64'd0);
        cycle();
        chk("basic_v2", 64'(out_v), 64'd1);
        chk("basic_o2", 64'(out), 64'hFFF6_FFF6);
        cycle();
        chk("basic_idle_v", 64'(out_v), 64'd0);
        chk("basic_idle_busy", 64'(busy), 64'd0);
        chk("basic_idle_rdy", 64'(in_rdy), 64'd1);

        // Backpressure, with a weight write attempted while busy.
        q_obs.delete();
        out_rdy = 1'b0;
        in = {8'd2, 8'd1}; in_v = 1'b1;
        cycle();
        in = {8'd4, 8'd3};
        cycle();
        in_v = 1'b0;
        wgt_we = 1'b1; wgt_addr = '0; wgt_data = $urandom();
        repeat (4) cycle();
        wgt_we = 1'b0;
        chk("bp_hold_v", 64'(out_v), 64'd1);
        chk("bp_hold_o", 64'(out), 64'h000A_000A);
        chk("bp_rdy", 64'(in_rdy), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        out_rdy = 1'b1;
        cycle();
        chk("bp_v2", 64'(out_v), 64'd1);
        chk("bp_o2", 64'(out), 64'hFFF6_FFF6);
        cycle();
        chk("bp_done", 64'(out_v), 64'd0);
        chk("bp_order_n", 64'(q_obs.size()), 64'd2);
        chk("bp_order0", (q_obs.size() > 0) ? 64'(q_obs[0]) : 'x, 64'h000A_000A);
        chk("bp_order1", (q_obs.size() > 1) ? 64'(q_obs[1]) : 'x, 64'hFFF6_FFF6);

        // Repeat run after the ignored write must match the directed weights.
        run("guard_rerun", 1, 0, cyc);

        // Mid-vector reset discards the partial result and keeps the weights.
        in = {8'd7, 8'd5}; in_v = 1'b1;
        cycle();
        in_v = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mrst_out_v", 64'(out_v), 64'd0);
        chk("mrst_in_rdy", 64'(in_rdy), 64'd1);
        chk("mrst_busy", 64'(busy), 64'd0);
        run("mrst_rerun", 1, 0, cyc);

        // Randomized weights and activations.
        for (int h = 0; h < MH; h++)
            for (int k = 0; k < MW; k++) W[h][k] = byte'($urandom_range(0, 255));
        load_w();
        for (int v = 0; v < 4; v++)
            for (int k = 0; k < MW; k++) X[v][k] = byte'($urandom_range(0, 255));
        run("rand_bp", 4, 1, cyc);
        for (int v = 0; v < 4; v++)
            for (int k = 0; k < MW; k++) X[v][k] = byte'($urandom_range(0, 255));
        run("b2b", 4, 0, cyc);
        chk("b2b_cycles", 64'(cyc), 64'd17);

        // Wraparound: 4 * 16 * 16 = 1024 wraps to 0 in an 8-bit accumulator.
        for (int h = 0; h < MH; h++)
            for (int k = 0; k < MW; k++) W[h][k] = 8'sd16;
        for (int k = 0; k < MW; k++) X[0][k] = 8'sd16;
        load_w();
        run("wrap", 1, 0, cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
